// File: rtl/mm_req_arbiter.sv
// Round-robin merge of NUM_REQ requester FIFOs onto one memory request port,
// with source-tagged ids so read responses can be steered back without lookup.
module mm_req_arbiter #(
    parameter  int NUM_REQ = 3,
    parameter  int DEPTH   = 4,
    parameter  int ID_W    = 8,
    parameter  int PADDR_W = 32,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_is_write,
    input  logic [NUM_REQ*ID_W-1:0]    req_id,
    input  logic [NUM_REQ*PADDR_W-1:0] req_paddr,
    input  logic [NUM_REQ*128-1:0]     req_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_is_write,
    output logic [SRC_W+ID_W-1:0]      mem_req_id,
    output logic [PADDR_W-1:0]         mem_req_paddr,
    output logic [127:0]               mem_req_data,
    input  logic                       mem_res_valid,
    input  logic [SRC_W+ID_W-1:0]      mem_res_id,
    input  logic [PADDR_W-1:0]         mem_res_paddr,
    input  logic [127:0]               mem_res_data,
    output logic [NUM_REQ-1:0]         res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [PADDR_W-1:0]         res_paddr,
    output logic [127:0]               res_data,
    output logic                       route_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic               is_write;
        logic [ID_W-1:0]    id;
        logic [PADDR_W-1:0] paddr;
        logic [127:0]       data;
    } entry_t;

    entry_t             r_mem    [NUM_REQ][DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr [NUM_REQ];
    logic [PTR_W-1:0]   r_rd_ptr [NUM_REQ];
    logic [CNT_W-1:0]   r_count  [NUM_REQ];
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [SRC_W-1:0]   r_lock_src;
    logic               r_lock;
    logic [NUM_REQ-1:0] r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic [PADDR_W-1:0] r_res_paddr;
    logic [127:0]       r_res_data;
    logic               r_route_err;

    entry_t             w_din  [NUM_REQ];
    entry_t             w_head [NUM_REQ];
    entry_t             w_sel;
    logic [NUM_REQ-1:0] w_nonempty;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_enq;
    logic [NUM_REQ-1:0] w_deq;
    logic [SRC_W-1:0]   w_grant;
    logic [SRC_W-1:0]   w_rr_next;
    logic               w_found;
    logic               w_fire;
    int unsigned        w_idx;
    logic [SRC_W-1:0]   w_src;
    logic               w_src_ok;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_din[i].is_write = req_is_write[i];
            w_din[i].id       = req_id[i*ID_W +: ID_W];
            w_din[i].paddr    = req_paddr[i*PADDR_W +: PADDR_W];
            w_din[i].data     = req_data[i*128 +: 128];
            w_nonempty[i]     = (r_count[i] != '0);
            w_ready[i]        = (r_count[i] != CNT_W'(DEPTH));
            w_head[i]         = r_mem[i][r_rd_ptr[i]];
            w_enq[i]          = req_valid[i] & w_ready[i];
        end
    end

    // Scan rr_ptr, rr_ptr+1, ... for the first non-empty FIFO; a stalled
    // request keeps its grant via the lock so outputs stay stable.
    always_comb begin
        w_grant = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_found && w_idx == i && w_nonempty[i]) begin
                    w_grant = SRC_W'(i);
                    w_found = 1'b1;
                end
            end
        end
        if (r_lock) w_grant = r_lock_src;

        w_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (32'(w_grant) == i) w_sel = w_head[i];

        w_fire    = (|w_nonempty) & mem_req_ready;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            w_deq[i] = w_fire && (32'(w_grant) == i);
        w_rr_next = (32'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + SRC_W'(1);
    end

    assign req_ready        = w_ready;
    assign mem_req_valid    = |w_nonempty;
    assign mem_req_is_write = w_sel.is_write;
    assign mem_req_id       = {w_grant, w_sel.id};
    assign mem_req_paddr    = w_sel.paddr;
    assign mem_req_data     = w_sel.data;

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (w_enq[i]) r_mem[i][r_wr_ptr[i]] <= w_din[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_src <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_enq[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                if (w_deq[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                r_count[i] <= r_count[i] + CNT_W'(w_enq[i]) - CNT_W'(w_deq[i]);
            end
            if (w_fire) begin
                r_rr_ptr <= w_rr_next;
                r_lock   <= 1'b0;
            end else if (mem_req_valid) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_grant;
            end
        end
    end

    assign w_src    = mem_res_id[SRC_W+ID_W-1:ID_W];
    assign w_src_ok = (32'(w_src) < NUM_REQ);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_res_valid <= '0;
            r_res_id    <= '0;
            r_res_paddr <= '0;
            r_res_data  <= '0;
            r_route_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++)
                r_res_valid[i] <= mem_res_valid && w_src_ok && (32'(w_src) == i);
            if (mem_res_valid && w_src_ok) begin
                r_res_id    <= mem_res_id[ID_W-1:0];
                r_res_paddr <= mem_res_paddr;
                r_res_data  <= mem_res_data;
            end
            if (mem_res_valid && !w_src_ok) r_route_err <= 1'b1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_paddr = r_res_paddr;
    assign res_data  = r_res_data;
    assign route_err = r_route_err;
endmodule

// File: tb/tb_mm_req_arbiter.sv
// Directed bench for mm_req_arbiter: routing, round-robin order, stall lock,
// FIFO full, writes, bad-route flag and mid-traffic reset.
module tb_mm_req_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 8;
    localparam int PADDR_W = 32;
    localparam int SRC_W   = 2;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_is_write;
    logic [NUM_REQ*ID_W-1:0]    req_id;
    logic [NUM_REQ*PADDR_W-1:0] req_paddr;
    logic [NUM_REQ*128-1:0]     req_data;
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic                       mem_req_is_write;
    logic [SRC_W+ID_W-1:0]      mem_req_id;
    logic [PADDR_W-1:0]         mem_req_paddr;
    logic [127:0]               mem_req_data;
    logic                       mem_res_valid;
    logic [SRC_W+ID_W-1:0]      mem_res_id;
    logic [PADDR_W-1:0]         mem_res_paddr;
    logic [127:0]               mem_res_data;
    logic [NUM_REQ-1:0]         res_valid;
    logic [ID_W-1:0]            res_id;
    logic [PADDR_W-1:0]         res_paddr;
    logic [127:0]               res_data;
    logic                       route_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] RD_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;

    mm_req_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(4), .ID_W(ID_W), .PADDR_W(PADDR_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_id(req_id), .req_paddr(req_paddr), .req_data(req_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_is_write(mem_req_is_write), .mem_req_id(mem_req_id),
        .mem_req_paddr(mem_req_paddr), .mem_req_data(mem_req_data),
        .mem_res_valid(mem_res_valid), .mem_res_id(mem_res_id),
        .mem_res_paddr(mem_res_paddr), .mem_res_data(mem_res_data),
        .res_valid(res_valid), .res_id(res_id), .res_paddr(res_paddr),
        .res_data(res_data), .route_err(route_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int src, input logic wr, input logic [7:0] id,
                           input logic [31:0] pa, input logic [127:0] d);
        req_is_write[src]         = wr;
        req_id[src*ID_W +: ID_W]  = id;
        req_paddr[src*32 +: 32]   = pa;
        req_data[src*128 +: 128]  = d;
    endtask

    logic [SRC_W+ID_W-1:0] rr_exp [6];

    initial begin
        reset = 1'b1; req_valid = '0; req_is_write = '0; req_id = '0;
        req_paddr = '0; req_data = '0; mem_req_ready = 1'b1;
        mem_res_valid = 1'b0; mem_res_id = '0; mem_res_paddr = '0; mem_res_data = '0;
        step(); step();
        reset = 1'b0;
        check("rst_res_valid", res_valid, 3'b000);
        check("rst_route_err", route_err, 1'b0);
        check("rst_req_ready", req_ready, 3'b111);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_res_data", res_data, 128'h0);

        // single read from source 1
        set_req(1, 1'b0, 8'h05, 32'h100, '0);
        req_valid = 3'b010;
        step();
        req_valid = '0;
        check("rd_valid", mem_req_valid, 1'b1);
        check("rd_id", mem_req_id, 10'h105);
        check("rd_paddr", mem_req_paddr, 32'h100);
        check("rd_is_write", mem_req_is_write, 1'b0);
        step();
        check("rd_drained", mem_req_valid, 1'b0);
        mem_res_valid = 1'b1; mem_res_id = 10'h105; mem_res_paddr = 32'h100; mem_res_data = RD_DATA;
        step();
        mem_res_valid = 1'b0;
        check("res_valid", res_valid, 3'b010);
        check("res_id", res_id, 8'h05);
        check("res_paddr", res_paddr, 32'h100);
        check("res_data", res_data, RD_DATA);
        step();
        check("res_valid_off", res_valid, 3'b000);
        check("res_data_hold", res_data, RD_DATA);

        // backpressure: rr_ptr is 2 now, so without the lock source 2 would steal the port
        mem_req_ready = 1'b0;
        set_req(0, 1'b0, 8'h30, 32'h300, '0);
        req_valid = 3'b001;
        step();
        set_req(2, 1'b0, 8'h32, 32'h320, '0);
        req_valid = 3'b100;
        check("bp_id0", mem_req_id, 10'h030);
        step();
        req_valid = '0;
        check("bp_id1", mem_req_id, 10'h030);
        check("bp_pa1", mem_req_paddr, 32'h300);
        step();
        check("bp_id2", mem_req_id, 10'h030);
        check("bp_valid2", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        step();
        check("bp_next_src2", mem_req_id, 10'h232);
        check("bp_next_pa", mem_req_paddr, 32'h320);
        step();
        check("bp_drained", mem_req_valid, 1'b0);

        // round robin: rr_ptr back at 0
        rr_exp = '{10'h010, 10'h111, 10'h212, 10'h020, 10'h121, 10'h222};
        for (int s = 0; s < NUM_REQ; s++) set_req(s, 1'b0, 8'(8'h10 + s), 32'(32'h1000 + s*16), '0);
        req_valid = 3'b111;
        step();
        for (int s = 0; s < NUM_REQ; s++) set_req(s, 1'b0, 8'(8'h20 + s), 32'(32'h2000 + s*16), '0);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_issue%0d", k), mem_req_id, rr_exp[k]);
            step();
            req_valid = '0;
        end
        check("rr_drained", mem_req_valid, 1'b0);

        // FIFO full on source 1
        mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(1, 1'b0, 8'(8'h40 + k), 32'(32'h4000 + k*16), '0);
            req_valid = 3'b010;
            step();
            check($sformatf("full_ready%0d", k), req_ready[1], (k >= 3) ? 1'b0 : 1'b1);
        end
        req_valid = '0;
        check("full_head", mem_req_id, 10'h140);
        mem_req_ready = 1'b1;
        step();
        check("full_ready_back", req_ready[1], 1'b1);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("full_drain%0d", k), mem_req_id, 10'(10'h140 + k));
            step();
        end
        check("full_no5th", mem_req_valid, 1'b0);

        // write from source 2
        set_req(2, 1'b1, 8'h50, 32'h40, 128'h1234);
        req_valid = 3'b100;
        step();
        req_valid = '0;
        check("wr_is_write", mem_req_is_write, 1'b1);
        check("wr_id", mem_req_id, 10'h250);
        check("wr_paddr", mem_req_paddr, 32'h40);
        check("wr_data", mem_req_data, 128'h1234);
        step();
        check("wr_drained", mem_req_valid, 1'b0);
        step();
        check("wr_no_res", res_valid, 3'b000);

        // bad route
        mem_res_valid = 1'b1; mem_res_id = 10'h300; mem_res_paddr = 32'h77; mem_res_data = 128'h99;
        step();
        mem_res_valid = 1'b0;
        check("bad_res_valid", res_valid, 3'b000);
        check("bad_route_err", route_err, 1'b1);
        check("bad_data_hold", res_data, RD_DATA);
        step();
        check("bad_sticky", route_err, 1'b1);

        // reset with two queued requests and a response in flight
        mem_req_ready = 1'b0;
        set_req(0, 1'b0, 8'h60, 32'h600, '0);
        req_valid = 3'b001;
        step(); step();
        req_valid = '0;
        check("pre_rst_valid", mem_req_valid, 1'b1);
        reset = 1'b1;
        mem_res_valid = 1'b1; mem_res_id = 10'h101;
        step();
        reset = 1'b0;
        mem_res_valid = 1'b0;
        check("post_rst_route_err", route_err, 1'b0);
        check("post_rst_req_ready", req_ready, 3'b111);
        check("post_rst_mem_valid", mem_req_valid, 1'b0);
        check("post_rst_res_valid", res_valid, 3'b000);
        step();
        check("post_rst_res_valid2", res_valid, 3'b000);
        check("post_rst_still_empty", mem_req_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mm_req_arbiter.md
Name: mm_req_arbiter

Overview:
- Sits directly upstream of the main memory model. Merges requests from NUM_REQ requesters (page walkers and L2 cache ports) into the single 128-bit memory request port, and routes read responses back to the requester that issued them.
- Each requester has its own FIFO. Requests are issued round-robin, one per cycle, with ready/valid backpressure on both sides.
- The source index is prepended to the request id so that responses can be steered back without any lookup table.

Parameters:
- NUM_REQ, 3, number of requesters (>=2).
- DEPTH, 4, per-requester FIFO entries (power of 2, >=2).
- ID_W, 8, requester id width.
- PADDR_W, 32, width of the 16-byte-aligned physical address field.
- SRC_W (local), $clog2(NUM_REQ), source-index width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester FIFO not full.
- req_is_write  in  NUM_REQ  1 = write, 0 = read.
- req_id  in  NUM_REQ*ID_W  requester transaction id.
- req_paddr  in  NUM_REQ*PADDR_W  aligned physical address.
- req_data  in  NUM_REQ*128  write data (ignored for reads).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_is_write  out  1  forwarded write flag.
- mem_req_id  out  SRC_W+ID_W  {source index, req_id}.
- mem_req_paddr  out  PADDR_W  forwarded address.
- mem_req_data  out  128  forwarded write data.
- mem_res_valid  in  1  read response from memory.
- mem_res_id  in  SRC_W+ID_W  echoed id.
- mem_res_paddr  in  PADDR_W  echoed address.
- mem_res_data  in  128  read data.
- res_valid  out  NUM_REQ  per-requester response valid (one-hot or zero).
- res_id  out  ID_W  lower ID_W bits of mem_res_id.
- res_paddr  out  PADDR_W  routed address.
- res_data  out  128  routed data.
- route_err  out  1  sticky: a response carried a source index >= NUM_REQ.

Behaviour:
- Reset (synchronous):
  - All FIFOs empty; rr_ptr = 0; lock = 0.
  - res_valid = 0; res_id, res_paddr, res_data = 0; route_err = 0.
  - Combinationally: req_ready = all 1, mem_req_valid = 0.
  - Reset asserted mid-transfer discards all queued requests and any in-flight response registration.
- FIFO enqueue:
  - req_ready[i] = (count[i] != DEPTH), derived from registered count only.
  - Entry is enqueued on req_valid[i] & req_ready[i].
  - Simultaneous enqueue and dequeue on the same FIFO leaves count unchanged. This is legal whenever count < DEPTH.
  - Pointers wrap modulo DEPTH.
- Arbitration (combinational grant):
  - If lock = 1, grant = lock_src.
  - Otherwise grant = first non-empty FIFO scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - mem_req_valid = (any FIFO non-empty). mem_req_* = head of the granted FIFO, with id = {grant[SRC_W-1:0], head.id}.
- Handshake:
  - On mem_req_valid & mem_req_ready: dequeue the granted FIFO; rr_ptr <= (grant+1) mod NUM_REQ; lock <= 0.
  - On mem_req_valid & !mem_req_ready: lock <= 1; lock_src <= grant. All mem_req_* outputs stay stable until accepted.
  - Throughput: 1 request per cycle. Enqueue-to-issue latency is 1 cycle minimum (the FIFO head is visible the cycle after enqueue).
- Writes produce no response. Reads get exactly one response, returned in whatever order memory returns them.
- Response routing (1-cycle registered stage):
  - src = mem_res_id[SRC_W+ID_W-1:ID_W].
  - If mem_res_valid & src < NUM_REQ: next cycle res_valid[src] = 1, and res_id/paddr/data take the echoed values.
  - If src >= NUM_REQ: response dropped, route_err <= 1 and held until reset.
  - When mem_res_valid = 0, res_valid = 0 the next cycle. Data fields hold their last value.
  - Response path has no backpressure: requesters must always accept.

Test Plan:
- Single read: reset, then requester 1 sends read id=0x05 paddr=0x100, mem_req_ready=1 → mem_req_valid the next cycle with mem_req_id={2'd1,8'h05}. Memory answers 1 cycle later with data 0xDEAD… → res_valid=3'b010 one cycle after mem_res_valid, with res_id=0x05 and res_paddr=0x100.
- Round-robin fairness: all 3 requesters each enqueue 2 reads in the same cycles, ready=1 → issue order is sources 0,1,2,0,1,2 on 6 consecutive cycles.
- Backpressure hold: source 0 queued, mem_req_ready=0 for 3 cycles, and source 2 enqueues during the stall → mem_req_* remain source 0's request throughout. After ready rises, source 0 issues, then source 2.
- FIFO full: hold mem_req_ready=0 and push 4 requests from source 1 → req_ready[1]=0 after the 4th enqueue. A 5th push is not accepted. One issue restores req_ready[1]=1 the next cycle.
- Writes: source 2 writes paddr=0x40 data=0x1234 → forwarded with is_write=1; no res_valid is ever asserted for it.
- Bad route/reset: inject mem_res_id={2'd3,8'h00} → all res_valid=0 and route_err=1. Then assert reset for 1 cycle with 2 entries queued → route_err=0, req_ready=3'b111, mem_req_valid=0.
